// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx_if : command-byte handshake between a requester and the PS/2  |
// |                  host transmitter.                                         |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;

   modport master (output tx_valid, tx_data,
                   input  tx_ready, tx_busy, tx_done, tx_err);
   modport slave  (input  tx_valid, tx_data,
                   output tx_ready, tx_busy, tx_done, tx_err);
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx : host-to-device PS/2 transmitter driving open-drain pads.     |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_host_tx #(
   parameter int CLK_FREQ   = 28_000_000,
   parameter int INHIBIT_US = 120,
   parameter int REQ_US     = 5,
   parameter int TIMEOUT_US = 15000,
   parameter int FILTER     = 8
) (
   input  wire          clk28,
   input  wire          rst_n,
   ps2_host_tx_if.slave tx,
   input  wire          ps2_clk_in,
   input  wire          ps2_dat_in,
   output logic         ps2_clk_out,
   output logic         ps2_dat_out
);
   localparam int c_INH   = (CLK_FREQ / 1_000_000) * INHIBIT_US;
   localparam int c_REQ   = (CLK_FREQ / 1_000_000) * REQ_US;
   localparam int c_TMO   = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
   localparam int c_INH_W = (c_INH > 1) ? $clog2(c_INH) : 1;
   localparam int c_REQ_W = (c_REQ > 1) ? $clog2(c_REQ) : 1;
   localparam int c_TMO_W = (c_TMO > 1) ? $clog2(c_TMO) : 1;
   localparam int c_FLT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

   localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(c_INH - 1);
   localparam logic [c_REQ_W-1:0] c_REQ_LAST = c_REQ_W'(c_REQ - 1);
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(c_TMO - 1);
   localparam logic [c_FLT_W-1:0] c_FLT_LAST = c_FLT_W'(FILTER - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_BITS, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
   } state_t;

   state_t                       state_q, state_d;
   logic [1:0]                   sync1_q, sync1_d;
   logic [1:0]                   sync2_q, sync2_d;
   logic [1:0]                   filt_q, filt_d;
   logic [1:0][c_FLT_W-1:0]      fcnt_q, fcnt_d;
   logic                         clk_prev_q, clk_prev_d;
   logic [7:0]                   data_q, data_d;
   logic                         par_q, par_d;
   logic [3:0]                   idx_q, idx_d;
   logic                         dat_q, dat_d;
   logic [c_INH_W-1:0]           inh_q, inh_d;
   logic [c_REQ_W-1:0]           req_q, req_d;
   logic [c_TMO_W-1:0]           tmo_q, tmo_d;
   logic                         fall;
   logic                         timeout;
   logic [15:0]                  frame;

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sync1_q    <= 2'b11;
         sync2_q    <= 2'b11;
         filt_q     <= 2'b11;
         fcnt_q     <= '0;
         clk_prev_q <= 1'b1;
         data_q     <= '0;
         par_q      <= 1'b0;
         idx_q      <= '0;
         dat_q      <= 1'b1;
         inh_q      <= '0;
         req_q      <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         clk_prev_q <= clk_prev_d;
         data_q     <= data_d;
         par_q      <= par_d;
         idx_q      <= idx_d;
         dat_q      <= dat_d;
         inh_q      <= inh_d;
         req_q      <= req_d;
         tmo_q      <= tmo_d;
      end
   end

   // Bit 0 carries the clock pad, bit 1 the data pad.
   always_comb begin
      sync1_d    = {ps2_dat_in, ps2_clk_in};
      sync2_d    = sync1_q;
      clk_prev_d = filt_q[0];
      filt_d     = filt_q;
      fcnt_d     = '0;
      for (int b = 0; b < 2; b++) begin
         if (sync2_q[b] != filt_q[b]) begin
            if (fcnt_q[b] == c_FLT_LAST) begin
               filt_d[b] = sync2_q[b];
            end else begin
               fcnt_d[b] = fcnt_q[b] + 1'b1;
            end
         end
      end
   end

   assign fall    = clk_prev_q & ~filt_q[0];
   assign timeout = (tmo_q == c_TMO_LAST);
   assign frame   = {6'h3F, 1'b1, par_q, data_q};

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      par_d   = par_q;
      idx_d   = idx_q;
      dat_d   = dat_q;
      inh_d   = '0;
      req_d   = '0;
      tmo_d   = '0;
      if (state_q inside {S_BITS, S_ACK, S_WAIT_IDLE}) begin
         tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (tx.tx_valid) begin
               data_d  = tx.tx_data;
               par_d   = ~^tx.tx_data;
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (inh_q == c_INH_LAST) state_d = S_REQ;
            else                     inh_d   = inh_q + 1'b1;
         end
         S_REQ: begin
            if (req_q == c_REQ_LAST) begin
               state_d = S_BITS;
               idx_d   = '0;
               dat_d   = 1'b0;
            end else begin
               req_d = req_q + 1'b1;
            end
         end
         S_BITS: begin
            if (timeout) begin
               state_d = S_ERR;
            end else if (fall) begin
               dat_d = frame[idx_q];
               idx_d = idx_q + 1'b1;
               if (idx_q == 4'd9) state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (timeout)   state_d = S_ERR;
            else if (fall) state_d = filt_q[1] ? S_ERR : S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (timeout)             state_d = S_ERR;
            else if (filt_q == 2'b11) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign tx.tx_ready = (state_q == S_IDLE);
   assign tx.tx_busy  = (state_q != S_IDLE);
   assign tx.tx_done  = (state_q == S_DONE);
   assign tx.tx_err   = (state_q == S_ERR);
   assign ps2_clk_out = !(state_q inside {S_INHIBIT, S_REQ});
   // Start bit is held through REQ; in BITS the line follows the frame register.
   assign ps2_dat_out = (state_q == S_REQ)  ? 1'b0 :
                        (state_q == S_BITS) ? dat_q : 1'b1;
endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_host_tx : device model plus cycle-level checker for ps2_host_tx.   |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_host_tx;
   localparam int CLK_FREQ   = 2_000_000;
   localparam int INHIBIT_US = 120;
   localparam int REQ_US     = 5;
   localparam int TIMEOUT_US = 1000;
   localparam int FILTER     = 8;
   localparam int INH   = (CLK_FREQ / 1_000_000) * INHIBIT_US;
   localparam int REQ   = (CLK_FREQ / 1_000_000) * REQ_US;
   localparam int TMO   = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
   localparam int HALF  = 30;
   localparam int LIMIT = INH + REQ + 200;
   localparam int M_ACK = 0, M_NOACK = 1, M_TMO = 2, M_RST = 3;

   logic clk28 = 1'b0;
   logic rst_n = 1'b0;
   logic dev_clk = 1'b1;
   logic dev_dat = 1'b1;
   logic ps2_clk_out, ps2_dat_out;
   logic ps2_clk_pad, ps2_dat_pad;

   int n_assert = 0;
   int n_fail   = 0;
   int n_done   = 0;
   int n_err    = 0;
   int exp_mode = M_ACK;
   bit busy_m = 1'b0;
   bit end_pending = 1'b0;
   int k = 0;

   assign ps2_clk_pad = ps2_clk_out & dev_clk;
   assign ps2_dat_pad = ps2_dat_out & dev_dat;

   ps2_host_tx_if tx_if();

   ps2_host_tx #(
      .CLK_FREQ(CLK_FREQ), .INHIBIT_US(INHIBIT_US), .REQ_US(REQ_US),
      .TIMEOUT_US(TIMEOUT_US), .FILTER(FILTER)
   ) dut (
      .clk28      (clk28),
      .rst_n      (rst_n),
      .tx         (tx_if),
      .ps2_clk_in (ps2_clk_pad),
      .ps2_dat_in (ps2_dat_pad),
      .ps2_clk_out(ps2_clk_out),
      .ps2_dat_out(ps2_dat_out)
   );

   always #5 clk28 = ~clk28;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      n_assert++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return (ones % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   // Expected pad/handshake behaviour, timed from the accepting edge.
   always @(posedge clk28) begin
      #1;
      if (!rst_n) begin
         busy_m = 1'b0; end_pending = 1'b0; k = 0;
         chk1("rst_ready", tx_if.tx_ready, 1'b1);
         chk1("rst_busy",  tx_if.tx_busy,  1'b0);
         chk1("rst_done",  tx_if.tx_done,  1'b0);
         chk1("rst_err",   tx_if.tx_err,   1'b0);
         chk1("rst_clk",   ps2_clk_out,    1'b1);
         chk1("rst_dat",   ps2_dat_out,    1'b1);
      end else begin
         if (!busy_m && tx_if.tx_valid) begin
            busy_m = 1'b1; k = 0;
         end else if (end_pending) begin
            busy_m = 1'b0; end_pending = 1'b0;
         end else if (busy_m) begin
            k++;
         end
         chk1("ready", tx_if.tx_ready, !busy_m);
         chk1("busy",  tx_if.tx_busy,  busy_m);
         chk1("done_err_excl", tx_if.tx_done & tx_if.tx_err, 1'b0);
         if (busy_m && k < INH + REQ) begin
            chk1("clk_hold", ps2_clk_out, 1'b0);
            chk1("dat_hold", ps2_dat_out, (k >= INH) ? 1'b0 : 1'b1);
         end else begin
            chk1("clk_rel", ps2_clk_out, 1'b1);
         end
         if (!busy_m || tx_if.tx_done || tx_if.tx_err) chk1("dat_rel", ps2_dat_out, 1'b1);
         if (exp_mode == M_TMO && busy_m) chk1("tmo_time", tx_if.tx_err, (k == INH + REQ + TMO));
         if (exp_mode != M_ACK) chk1("no_done", tx_if.tx_done, 1'b0);
         if (exp_mode == M_ACK || exp_mode == M_RST) chk1("no_err", tx_if.tx_err, 1'b0);
         if (tx_if.tx_done) n_done++;
         if (tx_if.tx_err) n_err++;
         if (busy_m && (tx_if.tx_done || tx_if.tx_err)) end_pending = 1'b1;
      end
   end

   // Device side: bits[0]=start, bits[8:1]=data, bits[9]=parity, bits[10]=stop.
   task automatic dev_xfer(input int mode, input bit glitch, output logic [10:0] bits);
      int t;
      bits = '1;
      t = 0;
      while (ps2_clk_pad !== 1'b0 && t < LIMIT) begin @(negedge clk28); t++; end
      if (t >= LIMIT) begin bound_fail("dev_inhibit"); return; end
      t = 0;
      while (ps2_clk_pad !== 1'b1 && t < LIMIT) begin @(negedge clk28); t++; end
      if (t >= LIMIT) begin bound_fail("dev_release"); return; end
      bits[0] = ps2_dat_pad;
      if (mode == M_TMO) return;
      for (int n = 1; n <= 10; n++) begin
         repeat (HALF) @(negedge clk28);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk28);
         dev_clk = 1'b1;
         bits[n] = ps2_dat_pad;
         if (mode == M_RST && n == 3) begin
            repeat (5) @(negedge clk28);
            rst_n = 1'b0;
            @(negedge clk28);
            chk1("midrst_clk",   ps2_clk_out,    1'b1);
            chk1("midrst_dat",   ps2_dat_out,    1'b1);
            chk1("midrst_ready", tx_if.tx_ready, 1'b1);
            rst_n = 1'b1;
            return;
         end
         if (glitch) begin
            repeat (14) @(negedge clk28);
            dev_clk = 1'b0;
            repeat (5) @(negedge clk28);
            dev_clk = 1'b1;
         end
      end
      repeat (10) @(negedge clk28);
      if (mode == M_ACK) dev_dat = 1'b0;
      repeat (10) @(negedge clk28);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk28);
      dev_clk = 1'b1;
      repeat (10) @(negedge clk28);
      dev_dat = 1'b1;
   endtask

   task automatic check_frame(input string name, input logic [10:0] bits, input logic [7:0] b);
      chk1({name, "_start"}, bits[0], 1'b0);
      chki({name, "_data"}, int'(bits[8:1]), int'(b));
      chk1({name, "_par"}, bits[9], odd_par(b));
      chk1({name, "_stop"}, bits[10], 1'b1);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk28);
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = b;
      @(negedge clk28);
      tx_if.tx_valid = 1'b0;
   endtask

   task automatic xfer(input string name, input logic [7:0] b, input int mode,
                       input bit glitch, output logic [10:0] bits);
      int d0, e0, t;
      d0 = n_done;
      e0 = n_err;
      exp_mode = mode;
      send(b);
      dev_xfer(mode, glitch, bits);
      if (mode == M_RST) return;
      if (mode == M_TMO) begin
         chk1({name, "_start"}, bits[0], 1'b0);
         t = 0;
         while (tx_if.tx_err !== 1'b1 && t < TMO + 100) begin @(negedge clk28); t++; end
         chki({name, "_tmo_cycles"}, t, TMO);
      end else begin
         check_frame(name, bits, b);
      end
      t = 0;
      while (n_done == d0 && n_err == e0 && t < 3 * TMO) begin @(negedge clk28); t++; end
      if (t >= 3 * TMO) bound_fail({name, "_end"});
      repeat (3) @(negedge clk28);
      chki({name, "_ndone"}, n_done - d0, (mode == M_ACK) ? 1 : 0);
      chki({name, "_nerr"},  n_err - e0,  (mode == M_ACK) ? 0 : 1);
      chk1({name, "_busy"}, tx_if.tx_busy, 1'b0);
      chk1({name, "_clk"},  ps2_clk_out, 1'b1);
      chk1({name, "_dat"},  ps2_dat_out, 1'b1);
   endtask

   initial begin
      logic [10:0] bits;
      int t;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'h00;
      repeat (3) @(negedge clk28);
      chk1("init_ready", tx_if.tx_ready, 1'b1);
      chk1("init_clk", ps2_clk_out, 1'b1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk28);

      xfer("ed", 8'hED, M_ACK, 1'b0, bits);
      chki("ed_frame_lit", int'(bits), 32'h7DA);
      xfer("p00", 8'h00, M_ACK, 1'b0, bits);
      chk1("p00_lit", bits[9], 1'b1);
      xfer("p07", 8'h07, M_ACK, 1'b1, bits);
      chk1("p07_lit", bits[9], 1'b0);
      xfer("pff", 8'hFF, M_ACK, 1'b0, bits);
      chk1("pff_lit", bits[9], 1'b1);
      xfer("noack", 8'hA5, M_NOACK, 1'b0, bits);
      xfer("tmo", 8'h3C, M_TMO, 1'b0, bits);

      // tx_valid held for the whole transfer while the data changes to 0x55
      exp_mode = M_ACK;
      @(negedge clk28);
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'hED;
      @(negedge clk28);
      tx_if.tx_data  = 8'h55;
      dev_xfer(M_ACK, 1'b0, bits);
      chki("held_first", int'(bits[8:1]), 32'hED);
      t = 0;
      while (tx_if.tx_done !== 1'b1 && t < 3 * TMO) begin @(negedge clk28); t++; end
      if (t >= 3 * TMO) bound_fail("held_done");
      @(negedge clk28);
      chk1("held_ready_gap", tx_if.tx_ready, 1'b1);
      @(negedge clk28);
      chk1("held_reaccept", tx_if.tx_busy, 1'b1);
      tx_if.tx_valid = 1'b0;
      dev_xfer(M_ACK, 1'b0, bits);
      chki("held_second", int'(bits[8:1]), 32'h55);
      t = 0;
      while (tx_if.tx_busy !== 1'b0 && t < 3 * TMO) begin @(negedge clk28); t++; end
      if (t >= 3 * TMO) bound_fail("held_idle");

      xfer("midrst", 8'h81, M_RST, 1'b0, bits);
      repeat (3 * HALF) @(negedge clk28);
      xfer("after_rst", 8'h12, M_ACK, 1'b0, bits);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
